// File: rtl/shift_ctrl8.sv
// shift_ctrl8: sequencing controller for an 8-bit mux-based shift register.
// The register is held here. It is updated each cycle through the same 4:1 mux
// selection (sft_sel/sft_sin) that the controller drives out.
// Optional feature macro: SHIFT_CTRL_CARRY_EN adds res_carry, the last bit shifted out.
//
// Handshake contract for both ports:
// - A transfer happens on a rising clock edge where valid and ready are both 1.
// - cmd_op, cmd_amt and cmd_data are sampled only on the accepting edge.
// - res_valid stays at 1 and res_data is held stable until the edge where
//   res_ready=1 retires the result.
// - cmd_ready is high only in IDLE. The controller spends at least one cycle in
//   IDLE after each retirement.
module shift_ctrl8 #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sft_sel,
  output logic             sft_sin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
`ifdef SHIFT_CTRL_CARRY_EN
  output logic             res_carry,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] OP_LSL  = 2'b00;
  localparam logic [1:0] OP_LSR  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b11;

  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               res_valid_q, res_valid_d;

  // Mux select and serial-in bit for the current step, from state, op and register.
  always_comb begin
    sft_sel = SEL_HOLD;
    sft_sin = 1'b0;
    case (state_q)
      ST_LOAD:  sft_sel = SEL_LOAD;
      ST_SHIFT: begin
        case (op_q)
          OP_LSL:  sft_sel = SEL_LEFT;
          OP_LSR:  sft_sel = SEL_RIGHT;
          OP_ASR:  begin sft_sel = SEL_RIGHT; sft_sin = sreg_q[WIDTH-1]; end
          default: begin sft_sel = SEL_RIGHT; sft_sin = sreg_q[0];       end
        endcase
      end
      default: ;
    endcase
  end

  // Shifter datapath: one 4:1 mux per bit.
  always_comb begin
    sreg_d = sreg_q;
    case (sft_sel)
      SEL_HOLD: sreg_d = sreg_q;
      SEL_LOAD: sreg_d = data_q;
      SEL_LEFT: sreg_d = {sreg_q[WIDTH-2:0], sft_sin};
      default:  sreg_d = {sft_sin, sreg_q[WIDTH-1:1]};
    endcase
  end

  // FSM next state: capture the command, load, step `amt` times, then present the result.
  // res_valid is registered, so it rises one cycle after DONE is entered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    amt_d       = amt_q;
    data_d      = data_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          amt_d   = cmd_amt;
          data_d  = cmd_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = amt_q;
        state_d = (amt_q != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        count_d = count_q - AMT_ONE;
        if (count_q == AMT_ONE) state_d = ST_DONE;
      end
      default: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
    endcase
  end

  // State, command capture and shift register flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LSL;
      amt_q       <= '0;
      count_q     <= '0;
      data_q      <= '0;
      sreg_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      amt_q       <= amt_d;
      count_q     <= count_d;
      data_q      <= data_d;
      sreg_q      <= sreg_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = sreg_q;
  assign dbg_state = state_q;

`ifdef SHIFT_CTRL_CARRY_EN
  logic carry_q, carry_d;

  // Carry: cleared on load, then takes the outgoing bit on every shift step.
  always_comb begin
    carry_d = carry_q;
    if (state_q == ST_LOAD) begin
      carry_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      carry_d = (op_q == OP_LSL) ? sreg_q[WIDTH-1] : sreg_q[0];
    end
  end

  // Carry flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) carry_q <= 1'b0;
    else          carry_q <= carry_d;
  end

  assign res_carry = carry_q;
`endif

endmodule
